// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and the
// tick-counter width helper used by the receiver (and later the transmitter).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int NB_DATA_DEF       = 8;
  localparam int NB_OVERSAMPLE_DEF = 16;
  localparam int NB_STOP_TICKS_DEF = 16;

  // Counter must hold the larger of the bit period and the stop period.
  function automatic int cnt_w(input int nb_os, input int nb_stop);
    int m;
    m = (nb_os > nb_stop) ? nb_os : nb_stop;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: tick and serial line in, byte and strobes out.
interface uart_rx_if #(
  parameter int NB_DATA = 8
) ();

  logic               i_tick;
  logic               i_rx;
  logic [NB_DATA-1:0] o_data;
  logic               o_rx_done;
  logic               o_frame_err;

  modport master (
    output i_tick, i_rx,
    input  o_data, o_rx_done, o_frame_err
  );

  modport slave (
    input  i_tick, i_rx,
    output o_data, o_rx_done, o_frame_err
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is a parameter so an idle-high line comes out of reset as idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling tick; samples each bit at its
// midpoint and reports a good byte or a framing error with one-clk strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int NB_OVERSAMPLE = NB_OVERSAMPLE_DEF,
  parameter int NB_STOP_TICKS = NB_STOP_TICKS_DEF
) (
  input  logic      clk,
  input  logic      i_rst_n,
  uart_rx_if.slave  bus
);

  localparam int TW = cnt_w(NB_OVERSAMPLE, NB_STOP_TICKS);
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(NB_OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_BIT  = TW'(NB_OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_STOP = TW'(NB_STOP_TICKS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NB_DATA - 1);

  state_t             state, state_n;
  logic [TW-1:0]      tick_cnt, tick_n;
  logic [BW-1:0]      bit_cnt, bit_n;
  logic [NB_DATA-1:0] shift_q, shift_n;
  logic [NB_DATA-1:0] data_q, data_n;
  logic               done_q, done_n;
  logic               ferr_q, ferr_n;
  logic               rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .d       (bus.i_rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      data_q   <= data_n;
      done_q   <= done_n;
      ferr_q   <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_q;
    data_n  = data_q;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Start edge is taken on any clk, not only on a tick.
        if (!rx_s) begin
          state_n = ST_START;
          tick_n  = '0;
        end
      end
      ST_START: begin
        if (bus.i_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bus.i_tick) begin
          if (tick_cnt == TICK_BIT) begin
            tick_n  = '0;
            shift_n = {rx_s, shift_q[NB_DATA-1:1]};
            if (bit_cnt == LAST_BIT) state_n = ST_STOP;
            else                     bit_n   = bit_cnt + 1'b1;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bus.i_tick) begin
          if (tick_cnt == TICK_STOP) begin
            tick_n  = '0;
            state_n = ST_IDLE;
            if (rx_s) begin
              data_n = shift_q;
              done_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_rx_done   = done_q;
  assign bus.o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, directed glitch/reset/break
// sequences and randomized frames scored against a frame-level model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_PER_BIT = 64;  // tick every 4 clk, 16 ticks per bit

  logic clk = 1'b0;
  logic i_rst_n;

  uart_rx_if #(.NB_DATA(8)) bus ();

  uart_rx #(.NB_DATA(8), .NB_OVERSAMPLE(16), .NB_STOP_TICKS(16)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for baudrate_generator with NC_PER_TICK=3.
  initial begin
    bus.i_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bus.i_tick = 1'b1;
      @(posedge clk);
      #1 bus.i_tick = 1'b0;
    end
  end

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
  } vec_t;

  ev_t        ev_q[$];
  ev_t        exp_q[$];
  logic [7:0] last_good;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor: logs every strobe and checks exclusivity and pulse width.
  initial begin
    logic prev_strobe;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_rx_done || bus.o_frame_err) begin
        ev_q.push_back('{err: bus.o_frame_err, data: bus.o_data});
        chk("strobe_exclusive", 32'(bus.o_rx_done & bus.o_frame_err), 32'd0);
        chk("strobe_one_clk", 32'(prev_strobe), 32'd0);
      end
      prev_strobe = bus.o_rx_done | bus.o_frame_err;
    end
  end

  task automatic drive(input logic v, input int n);
    bus.i_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A bad frame holds the stop bit low for 3/4 bit, then idles long enough
  // that the receiver's re-entered START rejects the tail as a glitch.
  task automatic send_frame(input logic [7:0] b, input bit ok);
    drive(1'b0, CLK_PER_BIT);
    for (int i = 0; i < 8; i++) drive(b[i], CLK_PER_BIT);
    if (ok) drive(1'b1, CLK_PER_BIT);
    else begin
      drive(1'b0, 48);
      drive(1'b1, 80);
    end
  endtask

  // Frame-level reference: good stop -> byte delivered; bad stop -> error
  // reported with the last good byte still on o_data.
  function automatic void model_frame(input logic [7:0] b, input bit ok);
    if (ok) begin
      exp_q.push_back('{err: 1'b0, data: b});
      last_good = b;
    end else begin
      exp_q.push_back('{err: 1'b1, data: last_good});
    end
  endfunction

  task automatic compare_events(input string tag);
    int n;
    chk({tag, "_event_count"}, 32'(ev_q.size()), 32'(exp_q.size()));
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_event%0d", tag, i), 32'(ev_q[i]), 32'(exp_q[i]));
    ev_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[5];
    int   nerr;
    logic [7:0] b;
    bit   ok;

    vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, gap: 100};
    vecs[1] = '{data: 8'h00, stop_ok: 1'b1, gap: 0};
    vecs[2] = '{data: 8'hFF, stop_ok: 1'b1, gap: 0};
    vecs[3] = '{data: 8'h3C, stop_ok: 1'b1, gap: 40};
    vecs[4] = '{data: 8'h55, stop_ok: 1'b0, gap: 0};

    bus.i_rx  = 1'b1;
    i_rst_n   = 1'b0;
    last_good = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_o_data", 32'(bus.o_data), 32'h0);
    chk("reset_o_rx_done", 32'(bus.o_rx_done), 32'h0);
    chk("reset_o_frame_err", 32'(bus.o_frame_err), 32'h0);
    i_rst_n = 1'b1;
    drive(1'b1, 50);

    // Table: single byte, back-to-back bytes, then a framing error.
    for (int i = 0; i < 5; i++) begin
      model_frame(vecs[i].data, vecs[i].stop_ok);
      send_frame(vecs[i].data, vecs[i].stop_ok);
      if (vecs[i].gap > 0) drive(1'b1, vecs[i].gap);
    end
    drive(1'b1, 200);
    compare_events("table");
    chk("ferr_keeps_data", 32'(bus.o_data), 32'h3C);

    // Glitch of 3 ticks must be rejected at mid start bit.
    drive(1'b0, 12);
    drive(1'b1, 300);
    chk("glitch_no_strobe", 32'(ev_q.size()), 32'd0);
    chk("glitch_data_kept", 32'(bus.o_data), 32'h3C);
    ev_q.delete();

    // Reset in the middle of data bit 4 of 0x81.
    b = 8'h81;
    drive(1'b0, CLK_PER_BIT);
    for (int i = 0; i < 4; i++) drive(b[i], CLK_PER_BIT);
    drive(b[4], 32);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_o_data", 32'(bus.o_data), 32'h0);
    chk("midrst_o_rx_done", 32'(bus.o_rx_done), 32'h0);
    chk("midrst_o_frame_err", 32'(bus.o_frame_err), 32'h0);
    bus.i_rx = 1'b1;
    repeat (10) @(posedge clk);
    #1 i_rst_n = 1'b1;
    drive(1'b1, 100);
    chk("midrst_no_strobe", 32'(ev_q.size()), 32'd0);
    ev_q.delete();
    last_good = 8'h00;
    model_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1);
    drive(1'b1, 200);
    compare_events("after_reset");

    // Break: ~3 frame times low gives one framing error per 152 ticks.
    drive(1'b0, 1900);
    drive(1'b1, 700);
    nerr = 0;
    foreach (ev_q[i]) if (ev_q[i].err) nerr++;
    chk("break_frame_errors", 32'(nerr), 32'd3);
    ev_q.delete();
    model_frame(8'h12, 1'b1);
    send_frame(8'h12, 1'b1);
    drive(1'b1, 200);
    compare_events("after_break");

    // Randomized frames, gaps and stop-bit faults.
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      model_frame(b, ok);
      send_frame(b, ok);
      drive(1'b1, $urandom_range(0, 100));
    end
    drive(1'b1, 200);
    compare_events("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; consumes the single-cycle oversampling tick from baudrate_generator (16 ticks per bit) and deserialises 8N1 frames from the asynchronous serial line.
- Outputs: received byte, one-cycle done strobe, one-cycle framing-error strobe.
- Sits between the pad-side i_rx line and the downstream interface/FIFO logic.

Parameters:
NB_DATA, 8, data bits per frame (LSB first)
NB_OVERSAMPLE, 16, ticks per bit period
NB_STOP_TICKS, 16, ticks spent in stop bit (16 = 1 stop bit, 32 = 2 stop bits)

Ports:
clk  input  1  system clock
i_rst_n  input  1  reset: asynchronous, active-low
i_tick  input  1  oversampling tick, one clk wide, from baudrate_generator
i_rx  input  1  serial line, asynchronous, idle high
o_data  output  NB_DATA  last correctly received byte
o_rx_done  output  1  one-clk pulse, o_data valid and updated this cycle
o_frame_err  output  1  one-clk pulse, stop bit sampled low

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state IDLE; tick counter 0, bit counter 0; shift reg 0.
  - o_data 0, o_rx_done 0, o_frame_err 0; synchroniser flops 1 (line-idle value).
  - Reset mid-frame aborts the frame; no strobe is emitted.
- i_rx passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s (2-clk delay).
- Counters advance only on clk edges with i_tick=1; they hold otherwise.
- The tick counter width is clog2(max(NB_OVERSAMPLE, NB_STOP_TICKS)).
- IDLE:
  - rx_s=0 -> START, tick counter cleared; no tick is required for this transition.
- START, on tick:
  - tick counter == NB_OVERSAMPLE/2-1 (7): mid start bit.
    - rx_s=0 -> DATA; tick counter and bit counter cleared.
    - rx_s=1 -> IDLE; glitch rejected, no strobe.
  - Otherwise the tick counter increments.
- DATA, on tick:
  - tick counter == NB_OVERSAMPLE-1 (15): sample rx_s into shift reg MSB, shift right (LSB-first assembly); tick counter cleared.
  - bit counter == NB_DATA-1 -> STOP; else bit counter +1.
  - Otherwise the tick counter increments.
- STOP, on tick:
  - tick counter == NB_STOP_TICKS-1: sample rx_s, then go to IDLE.
    - rx_s=1: o_data <= shift reg; o_rx_done=1 for exactly the next clk.
    - rx_s=0: o_frame_err=1 for exactly the next clk; o_data holds its previous value.
  - Otherwise the tick counter increments.
- o_rx_done and o_frame_err are registered, mutually exclusive, and never asserted outside the cycle after the STOP decision.
- Back-to-back frames:
  - The IDLE state is re-entered at the stop-bit midpoint+.
  - A start edge arriving right after the stop sample is accepted with no dead cycles.
- Line held low continuously (break):
  - Frame ends with o_frame_err.
  - FSM then re-enters START immediately, since rx_s=0 in IDLE.
  - Each further frame time yields another o_frame_err; no hang.
- Latency: o_rx_done asserts ~NB_OVERSAMPLE/2 + NB_OVERSAMPLE*NB_DATA + NB_STOP_TICKS ticks after the falling start edge, plus 3 clk.
- i_tick asserted on consecutive clks is legal; the FSM advances once per tick.
- No back-pressure: a new byte overwrites o_data; the consumer must capture it on o_rx_done.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams ST_IDLE, ST_START, ST_DATA, ST_STOP (2-bit);
  - default NB_DATA=8, NB_OVERSAMPLE=16;
  - helper constant for counter width.
- Sub-module sync_2ff: 2-flop synchroniser, async active-low reset, parameterised reset value (1 here). Reusable by the future transmitter.
- FSM, counters and shift register stay in uart_rx.

Test Plan:
- Bench setup: baudrate_generator with NC_PER_TICK=3 (tick every 4 clk, bit = 64 clk).
- Byte: send 0xA5 (8N1) -> o_data=0xA5 with one-clk o_rx_done; o_frame_err stays 0.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap -> three o_rx_done pulses; o_data = 0x00, 0xFF, 0x3C in order.
- Glitch: drive i_rx low for 12 clk (3 ticks), then high -> FSM returns to IDLE; no strobes; o_data unchanged.
- Framing error: send 0x55 with stop bit low -> o_frame_err one clk; o_rx_done 0; o_data keeps its prior value (0x3C).
- Reset mid-frame: assert i_rst_n low during data bit 4 of 0x81 -> all outputs 0 immediately; after release, clean frame 0x81 -> o_data=0x81, o_rx_done.
- Break: hold i_rx low for 3 frame times -> repeated o_frame_err pulses, one per frame time; after line returns high, frame 0x12 is received correctly.
